uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter PARITY_EN, default 0, meaning 1 = one parity bit follows the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning entry count; power of 2, at least 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port RxD, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port rd_en, input, 1 bit: pop the FIFO head.
REQ-010 SHALL have port clr_overrun, input, 1 bit: clear the overrun flag.
REQ-011 SHALL have port rd_data, output, 8 bits: FIFO head data byte.
REQ-012 SHALL have port rd_valid, output, 1 bit: FIFO not empty.
REQ-013 SHALL have port frame_err, output, 1 bit: head entry had a low stop bit.
REQ-014 SHALL have port parity_err, output, 1 bit: head entry failed the parity check.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag, a frame was dropped because the FIFO was full.
REQ-016 SHALL have port break_det, output, 1 bit: one-cycle pulse on detection of a line break.
REQ-017 SHALL have port rx_busy, output, 1 bit: receive FSM not in IDLE.

Function
REQ-018 SHALL synchronize RxD through 2 flops reset to 1; all line decisions SHALL use the synchronized value rxd_s.
REQ-019 SHALL generate a 16x oversample tick: DIV = round(CLK_FREQ/(BAUD*16)), minimum 1; a counter wraps at DIV-1 and asserts tick for 1 cycle on wrap.
REQ-020 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK, with a 4-bit tick counter and a 3-bit bit index.
REQ-021 IDLE: when rxd_s==0, SHALL go to START with the tick counter cleared.
REQ-022 START: on tick count 7, rxd_s==0 SHALL go to DATA with the counter cleared; rxd_s==1 SHALL return to IDLE as a glitch, with no push and no flag.
REQ-023 DATA: SHALL sample rxd_s every 16 ticks (bit centre), LSB first; after 8 bits, SHALL go to PARITY if PARITY_EN, else STOP.
REQ-024 PARITY: SHALL sample the bit after 16 ticks; error = (XOR of data and parity bit) != PARITY_ODD.
REQ-025 STOP: SHALL sample after 16 ticks.
REQ-026 STOP with rxd_s==1: SHALL push {parity_err, frame_err=0, data} and go to IDLE.
REQ-027 STOP with rxd_s==0, and data==0 and (parity bit==0 or !PARITY_EN): SHALL pulse break_det, push nothing, and go to BREAK.
REQ-028 STOP with rxd_s==0 otherwise: SHALL push with frame_err=1, then go to BREAK.
REQ-029 BREAK: SHALL remain in BREAK until rxd_s==1, then go to IDLE; this prevents a false start.
REQ-030 Push SHALL occur in the cycle after the stop sample; rd_valid SHALL assert in the cycle after the push.
REQ-031 FIFO SHALL be show-ahead: rd_data, frame_err and parity_err SHALL reflect the head whenever rd_valid=1, and SHALL be 0 when empty.
REQ-032 rd_en with rd_valid=1 SHALL pop, with the next head visible the following cycle; rd_en with rd_valid=0 SHALL be ignored.
REQ-033 Push when full without a simultaneous pop: SHALL drop the new frame and set overrun.
REQ-034 Push with a simultaneous pop when full: SHALL perform both, with no overrun.
REQ-035 overrun SHALL stay set until clr_overrun=1; if a drop and clr_overrun coincide, set SHALL win.
REQ-036 Pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap naturally; full = MSBs differ and the rest equal.

Reset
REQ-037 rst high SHALL immediately force: FSM to IDLE; counters, pointers and overrun to 0; synchronizer flops to 1; all outputs to 0.
REQ-038 rst asserted mid-frame SHALL discard the partial frame and all FIFO contents.
REQ-039 After rst release, SHALL require rxd_s to fall before any frame is accepted.

Verification
(All scenarios use CLK_FREQ=1_600_000, BAUD=100_000, so DIV=1 and 16 clocks per bit.)
REQ-040 Frame 0xA5, 8N1 -> rd_valid=1, rd_data=0xA5, frame_err=0, parity_err=0; rd_en for 1 cycle -> rd_valid=0.
REQ-041 PARITY_EN=1, PARITY_ODD=0, frame 0x03 with parity bit 1 -> parity_err=1, rd_data=0x03.
REQ-042 5 frames 0x01..0x05 with no reads -> FIFO holds 0x01..0x04, overrun=1; clr_overrun -> overrun=0.
REQ-043 Line low for 12 bit times -> exactly one break_det pulse, no push; a later 0x55 frame -> rd_data=0x55.
REQ-044 Low pulse of 4 clocks on idle line -> FSM returns to IDLE; rd_valid and all flags stay 0.
REQ-045 rst asserted in bit 4 of a frame with 2 entries queued -> rd_valid=0 and rx_busy=0 immediately; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, optional parity, break detection and a
// show-ahead receive FIFO carrying per-byte frame/parity error flags.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  input  logic       rd_en,
  input  logic       clr_overrun,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       break_det,
  output logic       rx_busy
);

  localparam int DIV_RAW = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  function automatic logic parity_bad(input logic [7:0] d, input logic p);
    if (PARITY_EN == 0) return 1'b0;
    return ((^d) ^ p) != PARITY_ODD[0];
  endfunction

  logic             rxd_m, rxd_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [2:0]       state;
  logic [3:0]       tcnt;
  logic [2:0]       bidx;
  logic [7:0]       shreg;
  logic             pbit;
  logic             push_req, perr_q, ferr_q;
  logic [AW:0]      wptr, rptr;
  logic [9:0]       mem [FIFO_DEPTH];
  logic [9:0]       head;
  logic             empty, full, pop, do_push, bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= RxD;
      rxd_s <= rxd_m;
    end
  end

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Receive FSM: start validated at half-bit, every later sample a full bit on.
  assign bit_end = tick && (tcnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      bidx      <= '0;
      push_req  <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      break_det <= 1'b0;
    end else begin
      push_req  <= 1'b0;
      break_det <= 1'b0;
      case (state)
        S_IDLE: if (!rxd_s) begin
          state <= S_START;
          tcnt  <= '0;
        end
        S_START: if (tick) begin
          if (tcnt == 4'd7) begin
            tcnt  <= '0;
            bidx  <= '0;
            state <= rxd_s ? S_IDLE : S_DATA;
          end else tcnt <= tcnt + 4'd1;
        end
        S_DATA: if (tick) begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            bidx <= bidx + 3'd1;
            if (bidx == 3'd7) state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: if (tick) begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd15) state <= S_STOP;
        end
        S_STOP: if (tick) begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            perr_q <= parity_bad(shreg, pbit);
            if (rxd_s) begin
              push_req <= 1'b1;
              ferr_q   <= 1'b0;
              state    <= S_IDLE;
            end else if (shreg == 8'h00 && (PARITY_EN == 0 || !pbit)) begin
              break_det <= 1'b1;
              state     <= S_BREAK;
            end else begin
              push_req <= 1'b1;
              ferr_q   <= 1'b1;
              state    <= S_BREAK;
            end
          end
        end
        S_BREAK: if (rxd_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DATA && bit_end)   shreg <= {rxd_s, shreg[7:1]};
    if (state == S_START)             pbit  <= 1'b0;
    if (state == S_PARITY && bit_end) pbit  <= rxd_s;
  end

  assign rx_busy = (state != S_IDLE);

  // FIFO: a push stalled by a full FIFO still lands if a pop frees a slot.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = rd_en && !empty;
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push_req && full && !pop) overrun <= 1'b1;
      else if (clr_overrun)         overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= {perr_q, ferr_q, shreg};
  end

  assign head       = mem[rptr[AW-1:0]];
  assign rd_valid   = !empty;
  assign rd_data    = empty ? 8'h00 : head[7:0];
  assign frame_err  = empty ? 1'b0  : head[8];
  assign parity_err = empty ? 1'b0  : head[9];

endmodule
